// File: rtl/arith_core_mod_if.sv
// Beat/result bus for arith_core_mod: the window feeder drives in/weight/en,
// the core returns out/out_en.
interface arith_core_mod_if;
    logic [71:0] in;
    logic [71:0] weight;
    logic        en;
    logic [7:0]  out;
    logic        out_en;

    modport master (
        output in, weight, en,
        input  out, out_en
    );

    modport slave (
        input  in, weight, en,
        output out, out_en
    );
endinterface

// File: rtl/arith_core_mod.sv
// Conv-layer PE datapath: 9 signed MACs + bias, multi-beat accumulation, scale/saturate,
// optional ReLU and 4:1 max-pool. Define ARITH_CORE_ROUND_EN for round-half-up scaling.
module arith_core_mod #(
    parameter int N_TAP  = 9,
    parameter int DW     = 8,
    parameter int ACC_W  = 24,
    parameter int MP_WIN = 4
) (
    input  logic               clk,
    input  logic               reset,
    arith_core_mod_if.slave    bus,
    input  logic signed [15:0] bias,
    input  logic [2:0]         bound_level,
    input  logic [2:0]         step,
    input  logic               en_relu,
    input  logic               en_mp
);
    localparam int PW    = 2 * DW;
    localparam int SW    = PW + 4;
    localparam int MPC_W = $clog2(MP_WIN);
    localparam logic [MPC_W-1:0]        MP_LAST = MPC_W'(MP_WIN - 1);
    localparam logic signed [ACC_W:0]   SAT_MAX = (ACC_W+1)'(2**(DW-1) - 1);
    localparam logic signed [ACC_W:0]   SAT_MIN = (ACC_W+1)'(-(2**(DW-1)));

    // S1: products
    logic signed [PW-1:0]    prod_q [N_TAP];
    logic signed [PW-1:0]    prod_d [N_TAP];
    logic                    v1_q, v1_d;
    // S2: accumulation
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]              beat_q, beat_d;
    logic                    res_v_q, res_v_d;
    // S3: scaled/saturated value
    logic signed [DW-1:0]    val_q, val_d;
    logic                    val_v_q, val_v_d;
    // S4: pooling and output
    logic [MPC_W-1:0]        mp_cnt_q, mp_cnt_d;
    logic signed [DW-1:0]    mp_max_q, mp_max_d;
    logic signed [DW-1:0]    out_q, out_d;
    logic                    out_en_q, out_en_d;

    always_comb begin
        for (int unsigned i = 0; i < N_TAP; i++) begin
            prod_d[i] = prod_q[i];
            if (bus.en) begin
                prod_d[i] = $signed(bus.in[(N_TAP-1-i)*DW +: DW]) *
                            $signed(bus.weight[(N_TAP-1-i)*DW +: DW]);
            end
        end
        v1_d = bus.en;
    end

    logic signed [SW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N_TAP; i++) begin
            sum = sum + SW'(prod_q[i]);
        end

        acc_d   = acc_q;
        beat_d  = beat_q;
        res_v_d = 1'b0;
        if (v1_q) begin
            // Bias is folded in on the first beat so it lands exactly once per result.
            acc_d   = (beat_q == 3'd0) ? ACC_W'(bias) + ACC_W'(sum) : acc_q + ACC_W'(sum);
            res_v_d = (beat_q == step);
            beat_d  = (beat_q == step) ? 3'd0 : beat_q + 3'd1;
        end
    end

    logic [3:0]               shamt;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    scaled;
    logic signed [DW-1:0]     sat;
`ifdef ARITH_CORE_ROUND_EN
    logic signed [ACC_W:0]    rnd;
`endif

    always_comb begin
        shamt   = 4'd12 - {1'b0, bound_level};
`ifdef ARITH_CORE_ROUND_EN
        rnd     = (ACC_W+1)'(1) << (shamt - 4'd1);
        acc_ext = (ACC_W+1)'(acc_q) + rnd;
`else
        acc_ext = (ACC_W+1)'(acc_q);
`endif
        scaled  = acc_ext >>> shamt;

        if (scaled > SAT_MAX) begin
            sat = SAT_MAX[DW-1:0];
        end else if (scaled < SAT_MIN) begin
            sat = SAT_MIN[DW-1:0];
        end else begin
            sat = scaled[DW-1:0];
        end
        if (en_relu && sat[DW-1]) begin
            sat = '0;
        end

        val_d   = res_v_q ? sat : val_q;
        val_v_d = res_v_q;
    end

    logic signed [DW-1:0] pooled;

    always_comb begin
        out_d    = out_q;
        out_en_d = 1'b0;
        mp_cnt_d = mp_cnt_q;
        mp_max_d = mp_max_q;
        pooled   = (mp_cnt_q == '0 || val_q > mp_max_q) ? val_q : mp_max_q;

        if (val_v_q) begin
            if (!en_mp) begin
                out_d    = val_q;
                out_en_d = 1'b1;
            end else begin
                mp_max_d = pooled;
                if (mp_cnt_q == MP_LAST) begin
                    out_d    = pooled;
                    out_en_d = 1'b1;
                    mp_cnt_d = '0;
                end else begin
                    mp_cnt_d = mp_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_TAP; i++) begin
                prod_q[i] <= '0;
            end
            v1_q     <= 1'b0;
            acc_q    <= '0;
            beat_q   <= '0;
            res_v_q  <= 1'b0;
            val_q    <= '0;
            val_v_q  <= 1'b0;
            mp_cnt_q <= '0;
            mp_max_q <= '0;
            out_q    <= '0;
            out_en_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_TAP; i++) begin
                prod_q[i] <= prod_d[i];
            end
            v1_q     <= v1_d;
            acc_q    <= acc_d;
            beat_q   <= beat_d;
            res_v_q  <= res_v_d;
            val_q    <= val_d;
            val_v_q  <= val_v_d;
            mp_cnt_q <= mp_cnt_d;
            mp_max_q <= mp_max_d;
            out_q    <= out_d;
            out_en_q <= out_en_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.out_en = out_en_q;
endmodule

// File: tb/tb_arith_core_mod.sv
// Scoreboard bench for arith_core_mod: a behavioural model queues each expected
// strobe (value and edge number) as beats are driven; a negedge monitor checks them.
module tb_arith_core_mod;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic signed [15:0] bias;
    logic [2:0]         bound_level;
    logic [2:0]         step;
    logic               en_relu;
    logic               en_mp;

    arith_core_mod_if bus();

    arith_core_mod dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .bias        (bias),
        .bound_level (bound_level),
        .step        (step),
        .en_relu     (en_relu),
        .en_mp       (en_mp)
    );

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_strobe = 0;
    int   last_out = 0;

    int acc_m, beat_m, pool_cnt_m, pool_max_m;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_sum(input logic [71:0] a, input logic [71:0] w);
        int s;
        logic signed [7:0] x, y;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            x = a[71-8*k -: 8];
            y = w[71-8*k -: 8];
            s += int'(x) * int'(y);
        end
        return s;
    endfunction

    function automatic int model_scale(input int acc);
        int s;
        s = acc >>> (12 - int'(bound_level));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (en_relu && s < 0) s = 0;
        return s;
    endfunction

    function automatic logic [71:0] rand72();
        logic [71:0] r;
        r[31:0]  = $urandom();
        r[63:32] = $urandom();
        r[71:64] = 8'($urandom());
        return r;
    endfunction

    task automatic model_clear();
        sb.delete();
        acc_m = 0; beat_m = 0; pool_cnt_m = 0; pool_max_m = 0;
        last_out = 0;
    endtask

    // Called #1 after an edge; the beat is sampled on the next edge (cyc+1), output 3 edges later.
    task automatic model_beat(input logic [71:0] a, input logic [71:0] w);
        int s, v;
        exp_t e;
        s = model_sum(a, w);
        acc_m = (beat_m == 0) ? int'(bias) + s : acc_m + s;
        if (beat_m == int'(step)) begin
            beat_m = 0;
            v = model_scale(acc_m);
            if (!en_mp) begin
                e.val = v; e.cyc = cyc + 4; sb.push_back(e);
            end else begin
                if (pool_cnt_m == 0 || v > pool_max_m) pool_max_m = v;
                if (pool_cnt_m == 3) begin
                    e.val = pool_max_m; e.cyc = cyc + 4; sb.push_back(e);
                    pool_cnt_m = 0;
                end else begin
                    pool_cnt_m++;
                end
            end
        end else begin
            beat_m++;
        end
    endtask

    task automatic beat(input logic [71:0] a, input logic [71:0] w, input logic e);
        bus.in = a;
        bus.weight = w;
        bus.en = e;
        if (e) model_beat(a, w);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic signed [15:0] b, input logic [2:0] bl, input logic [2:0] st,
                           input logic relu, input logic mp);
        bias = b; bound_level = bl; step = st; en_relu = relu; en_mp = mp;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int diff;
        if (reset === 1'b0) begin
            if (bus.out_en === 1'b1) begin
                n_strobe++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe: out=%0d at edge %0d, none expected", $signed(bus.out), cyc);
                end else begin
                    e = sb.pop_front();
                    diff = int'($signed(bus.out)) - e.val;
`ifdef ARITH_CORE_ROUND_EN
                    if (diff > 1 || diff < -1) begin
`else
                    if (diff != 0) begin
`endif
                        n_err++;
                        $display("FAIL out_value: got %0d, expected %0d", $signed(bus.out), e.val);
                    end
                    n_cmp++;
                    if (cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL strobe_edge: got edge %0d, expected edge %0d", cyc, e.cyc);
                    end
`ifdef ARITH_CORE_ROUND_EN
                    last_out = int'($signed(bus.out));
`else
                    last_out = e.val;
`endif
                end
            end else begin
                n_cmp++;
                if (bus.out_en !== 1'b0 || int'($signed(bus.out)) != last_out) begin
                    n_err++;
                    $display("FAIL out_hold: out_en=%b out=%0d, expected out_en=0 out=%0d",
                             bus.out_en, $signed(bus.out), last_out);
                end
            end
        end
    end

    task automatic check_done(input string name, input int s0, input int want);
        idle(8);
        n_cmp++;
        if (n_strobe - s0 !== want) begin
            n_err++;
            $display("FAIL %s_strobes: got %0d strobes, expected %0d", name, n_strobe - s0, want);
        end
        n_cmp++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL %s_pending: %0d expected strobes never seen, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in = '0; bus.weight = '0; bus.en = 1'b0;
        set_cfg(16'sd0, 3'd0, 3'd0, 1'b0, 1'b0);
        model_clear();
        idle(3);
        n_cmp++;
        if (bus.out !== 8'd0 || bus.out_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: out=%h out_en=%b, expected out=00 out_en=0", bus.out, bus.out_en);
        end
        reset = 1'b0;
        check_done("reset_idle", n_strobe, 0);
    endtask

    task automatic test_single_beat();
        int s0 = n_strobe;
        set_cfg(16'sd0, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) beat({9{8'd64}}, {9{8'd64}}, 1'b1);
        check_done("single_beat", s0, 64);
    endtask

    task automatic test_saturation();
        int s0 = n_strobe;
        set_cfg(16'sd0, 3'd7, 3'd0, 1'b0, 1'b0);
        beat({9{8'd127}}, {9{8'd127}}, 1'b1);
        beat({9{8'h80}}, {9{8'd127}}, 1'b1);
        idle(6);
        en_relu = 1'b1;
        beat({9{8'h80}}, {9{8'd127}}, 1'b1);
        check_done("saturation", s0, 3);
    endtask

    task automatic test_maxpool();
        int s0 = n_strobe;
        set_cfg(16'sd0, 3'd0, 3'd0, 1'b0, 1'b1);
        beat({{3{8'd64}}, 48'd0}, {9{8'd64}}, 1'b1);
        beat({{5{8'd64}}, 32'd0}, {9{8'hC0}}, 1'b1);
        beat({{8{8'd96}}, 8'd0}, {9{8'd64}}, 1'b1);
        beat({{7{8'd64}}, 16'd0}, {9{8'd64}}, 1'b1);
        for (int i = 0; i < 60; i++) beat(rand72(), rand72(), 1'b1);
        check_done("maxpool", s0, 16);
    endtask

    task automatic test_accum_pool();
        int s0 = n_strobe;
        set_cfg(16'($urandom()), 3'($urandom()), 3'd1, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) beat(rand72(), rand72(), 1'b1);
        check_done("accum_pool", s0, 8);
    endtask

    task automatic test_gapped();
        int s0 = n_strobe;
        set_cfg(16'($urandom()), 3'd2, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            beat(rand72(), rand72(), 1'b1);
            beat(rand72(), rand72(), 1'b0);
            beat(rand72(), rand72(), 1'b0);
        end
        check_done("gapped", s0, 4);
    endtask

    task automatic test_reset_mid_window();
        int s0;
        set_cfg(16'sd100, 3'd1, 3'd0, 1'b0, 1'b1);
        beat(rand72(), rand72(), 1'b1);
        beat(rand72(), rand72(), 1'b1);
        idle(4);
        reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (bus.out !== 8'd0 || bus.out_en !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_state: out=%h out_en=%b, expected out=00 out_en=0", bus.out, bus.out_en);
        end
        idle(2);
        reset = 1'b0;
        s0 = n_strobe;
        for (int i = 0; i < 4; i++) beat(rand72(), rand72(), 1'b1);
        check_done("mid_reset_window", s0, 1);
    endtask

    task automatic test_back_to_back();
        int s0 = n_strobe;
        set_cfg(16'($urandom()), 3'($urandom()), 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) beat(rand72(), rand72(), 1'b1);
        check_done("back_to_back", s0, 40);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_saturation();
        test_maxpool();
        test_accum_pool();
        test_gapped();
        test_reset_mid_window();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
